// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake and one-entry skid buffer.
// Optional stall/flush performance counters under `PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
  parameter int                 DATA_W      = 128,
  parameter int                 CTRL_W      = 16,
  parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = '0
`ifdef PIPE_STAGE_PERF_EN
  ,parameter int                CNT_W       = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_PERF_EN
  ,output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0]  flush_count
`endif
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  main_data, skid_data;
  logic [CTRL_W-1:0]  main_ctrl, skid_ctrl;
  logic               in_fire, out_fire;
  logic               load_main, load_skid, main_from_skid;

  // Both handshake outputs decode the state register only, so in_ready
  // never depends combinationally on out_ready.
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_data;
  assign out_ctrl  = out_valid ? main_ctrl : CTRL_BUBBLE;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d   = ONE;
            load_main = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            load_main = 1'b1;
          end else if (in_fire) begin
            state_d   = TWO;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_d        = ONE;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Storage is cleared on reset but simply holds across a flush.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      if (load_main) begin
        main_data <= in_data;
        main_ctrl <= in_ctrl;
      end else if (main_from_skid) begin
        main_data <= skid_data;
        main_ctrl <= skid_ctrl;
      end
      if (load_skid) begin
        skid_data <= in_data;
        skid_ctrl <= in_ctrl;
      end
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic stall_hit, flush_hit;
  // A flush cycle is never a stall; it counts only if it discarded something.
  assign stall_hit = out_valid & ~out_ready & ~flush;
  assign flush_hit = flush & out_valid;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_hit) stall_count <= sat_inc(stall_count);
      if (flush_hit) flush_count <= sat_inc(flush_count);
    end
  end
`endif

endmodule
